// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the iterative multiply/divide unit:
//   operation encodings, FSM state constants, the divide-by-zero
//   quotient fill bit, and small op-decode helpers.
// ---------------------------------------------------------------------------
package muldiv_pkg;

   // Operation encodings as driven on muldiv_unit.op
   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   // FSM state encoding
   typedef logic [1:0] state_t;
   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_RUN  = 2'd1;
   localparam state_t S_FIX  = 2'd2;

   // Divide by zero leaves an all-ones quotient in LO. The package has no
   // width, so the fill bit is kept here and replicated by the user.
   localparam logic DIV0_LO_FILL = 1'b1;

   // op[1] selects divide, op[0] selects signed
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// ---------------------------------------------------------------------------
// muldiv_signfix
//   Combinational conditional two's-complement negate. WIDE=0 works on a
//   WIDTH-bit value, WIDE=1 on a 2*WIDTH-bit value. Used for operand
//   magnitudes at load time and for sign correction of results.
//
//   Ports:
//     neg   in   1   negate din when set, pass through otherwise
//     din   in   N   value (N = WIDTH or 2*WIDTH)
//     dout  out  N   din or -din
// ---------------------------------------------------------------------------
module muldiv_signfix
   import muldiv_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  bit WIDE  = 1'b0,
   localparam int N     = WIDE ? 2 * WIDTH : WIDTH
) (
   input  logic         neg,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout
);

   assign dout = neg ? (~din + N'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative radix-2 multiply/divide unit owning the HI/LO register pair.
//   MULT/MULTU use shift-add, DIV/DIVU use restoring division; both work on
//   operand magnitudes and apply sign correction in a final FIX cycle.
//
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     start        request an operation (sampled only in IDLE)
//     op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//     a, b         rs / rt operands
//     hi_we, lo_we MTHI / MTLO write enables (honoured only when not busy)
//     wdata        MTHI / MTLO data
//     busy         operation in progress
//     done         one-cycle pulse: new HI/LO valid this cycle
//     div0         qualified by done: last op was a divide by zero
//     hi, lo       architectural HI / LO
//
//   Handshake: start is a request with no ready; it is accepted exactly when
//   it is high on a clock edge while busy=0, and ignored otherwise (no
//   queueing). busy rises the cycle after acceptance and stays high until the
//   result is written; done pulses for one cycle with busy=0, at which point
//   a new start can be accepted immediately.
// ---------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNTW  = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t             state;
   logic [CNTW-1:0]    count;
   logic [1:0]         op_q;
   logic               neg_q;      // negate product / quotient
   logic               neg_r;      // negate remainder (dividend sign)
   logic               bzero_q;
   logic [WIDTH-1:0]   opb;        // |b|: multiplicand or divisor

   // Multiply: acc = {partial sum, remaining multiplier bits}.
   // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
   logic [2*WIDTH-1:0] acc;

   // ---------------- operand magnitudes at load ----------------
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign a_neg = op_is_signed(op) & a[WIDTH-1];
   assign b_neg = op_is_signed(op) & b[WIDTH-1];

   muldiv_signfix #(.WIDTH(WIDTH), .WIDE(1'b0)) u_amag (
      .neg  (a_neg),
      .din  (a),
      .dout (a_mag)
   );

   muldiv_signfix #(.WIDTH(WIDTH), .WIDE(1'b0)) u_bmag (
      .neg  (b_neg),
      .din  (b),
      .dout (b_mag)
   );

   // ---------------- one multiply step ----------------
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
   // Carry-out lands in the top bit as the whole accumulator shifts right.
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // ---------------- one restoring-divide step ----------------
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;

   // Next dividend bit leaves the top of the low half as quotient bits
   // enter at the bottom.
   assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opb};
   assign div_ge    = (div_shift >= {1'b0, opb});
   assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign div_next  = {div_rem, acc[WIDTH-2:0], div_ge};

   // ---------------- sign correction for FIX ----------------
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_s, rem_s;

   muldiv_signfix #(.WIDTH(WIDTH), .WIDE(1'b1)) u_prod (
      .neg  (neg_q),
      .din  (acc),
      .dout (prod_s)
   );

   muldiv_signfix #(.WIDTH(WIDTH), .WIDE(1'b0)) u_quo (
      .neg  (neg_q),
      .din  (acc[WIDTH-1:0]),
      .dout (quo_s)
   );

   // With b==0 the divide loop leaves |a| as the remainder, so correcting
   // it with the dividend sign restores the original a for HI.
   muldiv_signfix #(.WIDTH(WIDTH), .WIDE(1'b0)) u_rem (
      .neg  (neg_r),
      .din  (acc[2*WIDTH-1:WIDTH]),
      .dout (rem_s)
   );

   assign busy = (state != S_IDLE);

   // ---------------- state and registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         count   <= '0;
         op_q    <= OP_MULTU;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         bzero_q <= 1'b0;
         opb     <= '0;
         acc     <= '0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
         div0    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
               if (start) begin
                  acc     <= {{WIDTH{1'b0}}, a_mag};
                  opb     <= b_mag;
                  op_q    <= op;
                  neg_q   <= a_neg ^ b_neg;
                  neg_r   <= a_neg;
                  bzero_q <= (b == '0);
                  count   <= CNTW'(WIDTH);
                  div0    <= 1'b0;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               acc   <= op_is_div(op_q) ? div_next : mul_next;
               count <= count - CNTW'(1);
               if (count == CNTW'(1)) state <= S_FIX;
            end
            S_FIX: begin
               if (op_is_div(op_q)) begin
                  hi <= rem_s;
                  if (bzero_q) begin
                     lo   <= {WIDTH{DIV0_LO_FILL}};
                     div0 <= 1'b1;
                  end else begin
                     lo <= quo_s;
                  end
               end else begin
                  {hi, lo} <= prod_s;
               end
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit (WIDTH=32): directed cases, busy-time
//   interference, reset abort, MTLO+start overlap and randomized operations
//   checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a, b, wdata;
   logic         hi_we, lo_we;
   logic         busy, done, div0;
   logic [W-1:0] hi, lo;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   logic [W-1:0] exp_q[$];

   muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .div0  (div0),
      .hi    (hi),
      .lo    (lo)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic void model(input logic [1:0] mop, input logic [W-1:0] ma,
                                 input logic [W-1:0] mb, output logic [W-1:0] ehi,
                                 output logic [W-1:0] elo, output logic ed0);
      logic [2*W-1:0] up;
      longint         sp;
      int             sa, sb;
      ed0 = 1'b0;
      case (mop)
         2'b00: begin
            up = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
            {ehi, elo} = up;
         end
         2'b01: begin
            sp = longint'($signed(ma)) * longint'($signed(mb));
            {ehi, elo} = sp;
         end
         default: begin
            if (mb == 0) begin
               elo = '1;
               ehi = ma;
               ed0 = 1'b1;
            end else if (mop == 2'b10) begin
               elo = ma / mb;
               ehi = ma % mb;
            end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
               elo = ma;
               ehi = '0;
            end else begin
               sa  = ma;
               sb  = mb;
               elo = sa / sb;
               ehi = sa % sb;
            end
         end
      endcase
   endfunction

   // ---------------- drivers ----------------
   // Present a start for one edge; returns #1 after the accepting edge.
   task automatic issue(input logic [1:0] iop, input logic [W-1:0] ia,
                        input logic [W-1:0] ib);
      @(negedge clk);
      start = 1'b1;
      op    = iop;
      a     = ia;
      b     = ib;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges until done (bounded); busy must be high before done and
   // low with done.
   task automatic wait_done(output int lat, output int busy_bad);
      lat      = -1;
      busy_bad = 0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            if (busy) busy_bad++;
            break;
         end
         if (!busy) busy_bad++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_cnt++;
      if ({busy, done, div0} !== 3'b000)
         $display("FAIL reset_flags got %b exp 000", {busy, done, div0});
      else pass_cnt++;
      chk_cnt++;
      if (hi !== '0) $display("FAIL reset_hi got %h exp 0", hi);
      else pass_cnt++;
      chk_cnt++;
      if (lo !== '0) $display("FAIL reset_lo got %h exp 0", lo);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_directed();
      logic [1:0]   t_op [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11};
      logic [W-1:0] t_a  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9,
                                 32'd100, 32'h8000_0000};
      logic [W-1:0] t_b  [5] = '{32'hFFFF_FFFF, 32'd5, 32'd2, 32'd0, 32'hFFFF_FFFF};
      logic [W-1:0] t_hi [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h0000_0064, 32'h0};
      logic [W-1:0] t_lo [5] = '{32'h0000_0001, 32'hFFFF_FFF1, 32'hFFFF_FFFD,
                                 32'hFFFF_FFFF, 32'h8000_0000};
      logic         t_d0 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      int lat, bb;
      for (int i = 0; i < 5; i++) begin
         issue(t_op[i], t_a[i], t_b[i]);
         wait_done(lat, bb);
         chk_cnt++;
         if (lat !== LAT) $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, LAT);
         else pass_cnt++;
         chk_cnt++;
         if (bb !== 0) $display("FAIL dir%0d_busy got %0d bad cycles exp 0", i, bb);
         else pass_cnt++;
         chk_cnt++;
         if (hi !== t_hi[i]) $display("FAIL dir%0d_hi got %h exp %h", i, hi, t_hi[i]);
         else pass_cnt++;
         chk_cnt++;
         if (lo !== t_lo[i]) $display("FAIL dir%0d_lo got %h exp %h", i, lo, t_lo[i]);
         else pass_cnt++;
         chk_cnt++;
         if (div0 !== t_d0[i]) $display("FAIL dir%0d_div0 got %b exp %b", i, div0, t_d0[i]);
         else pass_cnt++;
      end
      @(posedge clk);
      #1;
      chk_cnt++;
      if (done !== 1'b0) $display("FAIL done_pulse got %b exp 0", done);
      else pass_cnt++;
   endtask

   task automatic test_div0_clear();
      int lat, bb;
      issue(2'b10, 32'd5, 32'd0);
      wait_done(lat, bb);
      chk_cnt++;
      if (div0 !== 1'b1) $display("FAIL div0_set got %b exp 1", div0);
      else pass_cnt++;
      issue(2'b00, 32'd1, 32'd1);
      chk_cnt++;
      if (div0 !== 1'b0) $display("FAIL div0_clear got %b exp 0", div0);
      else pass_cnt++;
      wait_done(lat, bb);
      chk_cnt++;
      if (lat !== LAT) $display("FAIL div0_next_latency got %0d exp %0d", lat, LAT);
      else pass_cnt++;
   endtask

   task automatic test_busy_ignore();
      int lat, bb;
      @(negedge clk);
      hi_we = 1'b1;
      wdata = 32'h5555;
      @(posedge clk);
      #1;
      hi_we = 1'b0;
      chk_cnt++;
      if (hi !== 32'h5555) $display("FAIL mthi_idle got %h exp 00005555", hi);
      else pass_cnt++;
      issue(2'b00, 32'd7, 32'd6);
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      op    = 2'b10;
      a     = 32'd99;
      b     = 32'd0;
      hi_we = 1'b1;
      wdata = 32'h1234;
      @(posedge clk);
      #1;
      start = 1'b0;
      hi_we = 1'b0;
      chk_cnt++;
      if (hi !== 32'h5555) $display("FAIL mthi_busy got %h exp 00005555", hi);
      else pass_cnt++;
      wait_done(lat, bb);
      chk_cnt++;
      if (lat + 5 !== LAT) $display("FAIL ignore_latency got %0d exp %0d", lat + 5, LAT);
      else pass_cnt++;
      chk_cnt++;
      if ({hi, lo} !== {32'd0, 32'd42})
         $display("FAIL ignore_result got %h_%h exp 00000000_0000002a", hi, lo);
      else pass_cnt++;
      chk_cnt++;
      if (div0 !== 1'b0) $display("FAIL ignore_div0 got %b exp 0", div0);
      else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      int pulses;
      issue(2'b10, 32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_cnt++;
      if ({busy, done} !== 2'b00) $display("FAIL abort_flags got %b exp 00", {busy, done});
      else pass_cnt++;
      chk_cnt++;
      if ({hi, lo} !== '0) $display("FAIL abort_hilo got %h_%h exp 0_0", hi, lo);
      else pass_cnt++;
      @(negedge clk);
      reset  = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done || busy) pulses++;
      end
      chk_cnt++;
      if (pulses !== 0) $display("FAIL abort_no_done got %0d active cycles exp 0", pulses);
      else pass_cnt++;
   endtask

   task automatic test_write_with_start();
      int lat, bb;
      @(negedge clk);
      lo_we = 1'b1;
      wdata = 32'hCAFE_BABE;
      start = 1'b1;
      op    = 2'b00;
      a     = 32'd2;
      b     = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      lo_we = 1'b0;
      chk_cnt++;
      if (lo !== 32'hCAFE_BABE) $display("FAIL mtlo_start_lo got %h exp cafebabe", lo);
      else pass_cnt++;
      chk_cnt++;
      if (busy !== 1'b1) $display("FAIL mtlo_start_busy got %b exp 1", busy);
      else pass_cnt++;
      wait_done(lat, bb);
      chk_cnt++;
      if (lat !== LAT) $display("FAIL mtlo_start_latency got %0d exp %0d", lat, LAT);
      else pass_cnt++;
      chk_cnt++;
      if ({hi, lo} !== {32'd0, 32'd6})
         $display("FAIL mtlo_start_result got %h_%h exp 00000000_00000006", hi, lo);
      else pass_cnt++;
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return W'($urandom_range(1, 20));
         4:       return -W'($urandom_range(1, 20));
         default: return W'($urandom);
      endcase
   endfunction

   task automatic test_random();
      logic [1:0]   rop;
      logic [W-1:0] ra, rb, ehi, elo, gh, gl;
      logic         ed0;
      int           lat, bb;
      for (int n = 0; n < 30; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = pick_operand();
         rb  = pick_operand();
         model(rop, ra, rb, ehi, elo, ed0);
         exp_q.push_back(ehi);
         exp_q.push_back(elo);
         issue(rop, ra, rb);
         wait_done(lat, bb);
         gh = exp_q.pop_front();
         gl = exp_q.pop_front();
         chk_cnt++;
         if (lat !== LAT || bb !== 0)
            $display("FAIL rnd%0d_timing got lat %0d busy_bad %0d exp lat %0d", n, lat, bb, LAT);
         else pass_cnt++;
         chk_cnt++;
         if (hi !== gh || lo !== gl)
            $display("FAIL rnd%0d_result op %0d a %h b %h got %h_%h exp %h_%h",
                     n, rop, ra, rb, hi, lo, gh, gl);
         else pass_cnt++;
         chk_cnt++;
         if (div0 !== ed0) $display("FAIL rnd%0d_div0 got %b exp %b", n, div0, ed0);
         else pass_cnt++;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_directed();
      test_div0_clear();
      test_busy_ignore();
      test_reset_abort();
      test_write_with_start();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
